// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// The redirect-pulse contract (pc_j_valid + next_pc) is also used by control_unit.
package fetch_pkg;
    localparam int              XLEN             = 32;
    localparam int              INSTR_BYTES      = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Registered {pc,instr} prefetch FIFO. Flush wins over a same-cycle push or pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);
    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time and
// buffers returned words; redirects flush buffered and in-flight instructions.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            decode_ready,
    input  logic            pc_j_valid,
    input  logic [XLEN-1:0] next_pc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic            epoch_q, epoch_d, req_epoch_q, req_epoch_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, issue_pc_q, issue_pc_d;

    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_din, fifo_dout;
    logic            handshake, rsp;

    // Issue only when idle; the occupancy check then covers occupancy+outstanding.
    assign imem_req    = rst_n && !pc_j_valid && (state_q == S_IDLE)
                         && (fifo_count < CW'(FIFO_DEPTH));
    assign imem_addr   = fetch_pc_q;
    assign handshake   = imem_req && imem_ready;
    assign rsp         = (state_q == S_WAIT) && imem_rvalid;
    assign fifo_push   = rsp && (req_epoch_q == epoch_q) && !pc_j_valid
                         && (!fifo_full || fifo_pop);
    assign fifo_pop    = instr_valid && decode_ready;
    assign fifo_din    = '{pc: issue_pc_q, instr: imem_rdata};
    assign instr_valid = !fifo_empty;
    assign instr       = fifo_dout.instr;
    assign instr_pc    = fifo_dout.pc;

    always_comb begin
        state_d     = state_q;
        epoch_d     = epoch_q;
        req_epoch_d = req_epoch_q;
        fetch_pc_d  = fetch_pc_q;
        issue_pc_d  = issue_pc_q;
        case (state_q)
            S_IDLE: if (handshake) begin
                state_d     = S_WAIT;
                req_epoch_d = epoch_q;
                issue_pc_d  = fetch_pc_q;
                fetch_pc_d  = fetch_pc_q + XLEN'(INSTR_BYTES);
            end
            S_WAIT: if (imem_rvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (pc_j_valid) begin
            fetch_pc_d = {next_pc[XLEN-1:2], 2'b00};
            // Derive from the issue epoch so several redirects in one wait still mark it stale.
            if (state_q == S_WAIT) epoch_d = ~req_epoch_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            epoch_q     <= 1'b0;
            req_epoch_q <= 1'b0;
            fetch_pc_q  <= RESET_PC;
            issue_pc_q  <= RESET_PC;
        end else begin
            state_q     <= state_d;
            epoch_q     <= epoch_d;
            req_epoch_q <= req_epoch_d;
            fetch_pc_q  <= fetch_pc_d;
            issue_pc_q  <= issue_pc_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (pc_j_valid),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          DEPTH = 2;
    localparam int          NCYC  = 4000;

    logic        clk, rst_n;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        instr_valid, decode_ready, pc_j_valid;
    logic [31:0] instr, instr_pc, next_pc;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .decode_ready (decode_ready),
        .pc_j_valid   (pc_j_valid),
        .next_pc      (next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    // Reference model: expected PC stream, buffered words, one in-flight flag.
    logic [31:0] m_pc, m_ipc;
    bit          m_out, m_stale;
    logic [63:0] q[$];

    // Memory environment: one accepted request, answered after 1..4 cycles.
    bit          mp;
    int          mlat;
    logic [31:0] maddr;

    task automatic model_reset();
        m_pc = RPC; m_ipc = RPC; m_out = 0; m_stale = 0; q.delete();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".req"},  32'(imem_req),    32'd0);
        chk({tag, ".addr"}, imem_addr,        RPC);
        chk({tag, ".vld"},  32'(instr_valid), 32'd0);
        chk({tag, ".ins"},  instr,            32'd0);
        chk({tag, ".ipc"},  instr_pc,         32'd0);
    endtask

    initial begin
        bit          e_req, got_req, hs, pop, rsp;
        logic [31:0] got_addr;
        int          phase;

        rst_n = 1'b0; imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
        decode_ready = 0; pc_j_valid = 0; next_pc = '0;
        mp = 0; mlat = 0; maddr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset("por");

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            // Async reset pulses landing mid-operation, released on a later negedge.
            rst_n = !(cyc == 1500 || cyc == 3000 || cyc == 3001);
            phase = (cyc / 200) % 4;
            imem_rvalid  = mp && (mlat == 0);
            imem_rdata   = imem_rvalid ? mem_word(maddr) : $urandom;
            imem_ready   = !mp && ($urandom_range(0, 3) != 0);
            case (phase)
                0:       decode_ready = 1'b1;
                1:       decode_ready = $urandom_range(0, 1) == 1;
                2:       decode_ready = $urandom_range(0, 9) == 0;
                default: decode_ready = $urandom_range(0, 9) != 0;
            endcase
            pc_j_valid = $urandom_range(0, 13) == 0;
            case ($urandom_range(0, 4))
                0:       next_pc = 32'h0000_0100;
                1:       next_pc = 32'h0000_0203;
                2:       next_pc = 32'hFFFF_FFFC;
                3:       next_pc = 32'hFFFF_FFF8;
                default: next_pc = $urandom;
            endcase
            #1;
            got_req  = imem_req;
            got_addr = imem_addr;
            e_req    = 0;
            if (!rst_n) begin
                model_reset();
                check_reset("rst");
            end else begin
                e_req = !pc_j_valid && !m_out && (q.size() < DEPTH);
                chk("req",  32'(imem_req),    32'(e_req));
                chk("addr", imem_addr,        m_pc);
                chk("vld",  32'(instr_valid), 32'(q.size() > 0));
                if (q.size() > 0) begin
                    chk("ipc",   instr_pc, q[0][63:32]);
                    chk("instr", instr,    q[0][31:0]);
                end
            end

            @(posedge clk);
            if (imem_rvalid) mp = 0;
            else if (mp) mlat--;
            if (got_req && imem_ready) begin
                mp = 1; maddr = got_addr; mlat = $urandom_range(0, 3);
            end
            if (rst_n) begin
                hs  = e_req && imem_ready;
                pop = (q.size() > 0) && decode_ready;
                rsp = imem_rvalid && m_out;
                if (pc_j_valid) begin
                    q.delete();
                    if (rsp) begin m_out = 0; m_stale = 0; end
                    else if (m_out) m_stale = 1;
                    m_pc = {next_pc[31:2], 2'b00};
                end else begin
                    if (pop) void'(q.pop_front());
                    if (rsp) begin
                        m_out = 0;
                        if (!m_stale) q.push_back({m_ipc, imem_rdata});
                        m_stale = 0;
                    end
                    if (hs) begin
                        m_out = 1; m_stale = 0; m_ipc = m_pc; m_pc = m_pc + 32'd4;
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
